// File: rtl/store_align_buffer.sv
// ---------------------------------------------------------------------------
// store_align_buffer
//
// Store-side alignment and write buffer for the MEM stage of the pipeline.
// Turns sb/sh/sw requests into lane-replicated write data plus byte enables,
// rejects misaligned or illegal requests, queues good stores in a small FIFO
// and drains that FIFO to data memory over a req/ack handshake. It also tells
// the hazard unit when a load in MEM hits a word that still has a pending
// store.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   st_valid     MEM stage presents a store this cycle
//   st_op        00 sb, 01 sh, 10 sw, 11 illegal
//   st_addr      byte address of the store
//   st_data      rs2 value (low byte/half used for sb/sh)
//   st_ready     buffer can accept a store (FIFO not full)
//   st_err       one-cycle pulse after an accepted misaligned/illegal store
//   ld_addr      byte address of the load currently in MEM
//   ld_conflict  some queued store targets the same word as ld_addr
//   busy         FIFO non-empty
//   dm_req       write request to data memory
//   dm_addr      word address of the request (bits [1:0] are zero)
//   dm_wdata     lane-aligned write data
//   dm_be        byte enables, bit i covers dm_wdata[8i+7:8i]
//   dm_ack       memory accepted the current request
// ---------------------------------------------------------------------------
module store_align_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        st_err,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        busy,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  // FIFO storage: one word address, byte-enable and data field per entry
  logic [29:0] ent_addr [DEPTH];
  logic [3:0]  ent_be   [DEPTH];
  logic [31:0] ent_data [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic        full;
  logic        empty;
  logic        take;
  logic        push;
  logic        pop;
  logic        bad;
  logic [3:0]  new_be;
  logic [31:0] new_data;
  logic [1:0]  lane;
  logic        err_r;

  // Only the word part of the load address takes part in the comparison
  logic unused_ld_bits;
  assign unused_ld_bits = ^ld_addr[1:0];

  assign lane  = st_addr[1:0];
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == (PTR_W + 1)'(0));

  // No bypass: a full FIFO refuses a store even when a pop lands in the same cycle
  assign st_ready = !full;
  assign busy     = !empty;
  assign dm_req   = !empty;
  assign st_err   = err_r;

  assign take = st_valid && st_ready;
  assign push = take && !bad;
  assign pop  = dm_req && dm_ack;

  // Lane mapping and alignment check for the incoming store
  always_comb begin
    bad      = 1'b0;
    new_be   = 4'b0000;
    new_data = 32'h0000_0000;
    case (st_op)
      2'b00: begin
        new_be   = 4'b0001 << lane;
        new_data = {4{st_data[7:0]}};
      end
      2'b01: begin
        if (lane[0]) begin
          bad = 1'b1;
        end else begin
          bad = 1'b0;
        end
        new_be   = lane[1] ? 4'b1100 : 4'b0011;
        new_data = {2{st_data[15:0]}};
      end
      2'b10: begin
        if (lane != 2'b00) begin
          bad = 1'b1;
        end else begin
          bad = 1'b0;
        end
        new_be   = 4'b1111;
        new_data = st_data;
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

  // Head entry drives the memory port; zeros whenever the FIFO is empty
  always_comb begin
    if (empty) begin
      dm_addr  = 32'h0000_0000;
      dm_wdata = 32'h0000_0000;
      dm_be    = 4'b0000;
    end else begin
      dm_addr  = {ent_addr[rd_ptr], 2'b00};
      dm_wdata = ent_data[rd_ptr];
      dm_be    = ent_be[rd_ptr];
    end
  end

  // Word-match of the load against every live entry (head included even if
  // it is being acked; a store being accepted this cycle is not yet live)
  always_comb begin
    logic [PTR_W-1:0] offset;
    ld_conflict = 1'b0;
    offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr;
      if (({1'b0, offset} < count) && (ent_addr[i] == ld_addr[31:2])) begin
        ld_conflict = 1'b1;
      end else begin
        ld_conflict = ld_conflict;
      end
    end
  end

  // Pointers, occupancy counter and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_r  <= 1'b0;
    end else begin
      err_r <= take && bad;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; written only on a good push
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= 30'h0000_0000;
        ent_be[i]   <= 4'b0000;
        ent_data[i] <= 32'h0000_0000;
      end
    end else if (push) begin
      ent_addr[wr_ptr] <= st_addr[31:2];
      ent_be[wr_ptr]   <= new_be;
      ent_data[wr_ptr] <= new_data;
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
module tb_store_align_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_err;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        busy;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;

  int checks = 0;
  int errors = 0;

  // expected beat: {addr, be, wdata}
  logic [67:0] exp_q [$];

  store_align_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_err(st_err),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict), .busy(busy),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ack(dm_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each acked beat is compared against the scoreboard head
  always @(negedge clk) begin
    if (!rst && dm_req && dm_ack) begin
      logic [67:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got addr %h be %b data %h expected none",
                 dm_addr, dm_be, dm_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({dm_addr, dm_be, dm_wdata} !== e) begin
          errors++;
          $display("FAIL beat: got addr %h be %b data %h expected addr %h be %b data %h",
                   dm_addr, dm_be, dm_wdata, e[67:36], e[35:32], e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one store; push an expectation only when it should be enqueued
  task automatic store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic good, input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_data);
    int n;
    n = 0;
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = addr;
    st_data  = data;
    while (!st_ready && n < 20) begin
      step();
      n++;
    end
    if (!st_ready) begin
      chk("store_ready_timeout", {31'd0, st_ready}, 32'd1);
    end
    if (good) exp_q.push_back({e_addr, e_be, e_data});
    step();
    st_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    chk("drain_busy", {31'd0, busy}, 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_op = 2'b00; st_addr = 32'h0; st_data = 32'h0;
    ld_addr = 32'h0; dm_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, dm_req}, 32'd0);
    chk("rst_err", {31'd0, st_err}, 32'd0);
    chk("rst_addr", dm_addr, 32'h0);
    chk("rst_be", {28'd0, dm_be}, 32'd0);

    // byte lanes, continuous ack (push and pop together)
    dm_ack = 1'b1;
    store(2'b00, 32'h1000, 32'h0000_00A5, 1'b1, 32'h1000, 4'b0001, 32'hA5A5_A5A5);
    store(2'b00, 32'h1001, 32'h0000_00A5, 1'b1, 32'h1000, 4'b0010, 32'hA5A5_A5A5);
    store(2'b00, 32'h1002, 32'h0000_00A5, 1'b1, 32'h1000, 4'b0100, 32'hA5A5_A5A5);
    store(2'b00, 32'h1003, 32'h0000_00A5, 1'b1, 32'h1000, 4'b1000, 32'hA5A5_A5A5);
    // halfword / word
    store(2'b01, 32'h2002, 32'h1234_BEEF, 1'b1, 32'h2000, 4'b1100, 32'hBEEF_BEEF);
    store(2'b01, 32'h2000, 32'h1234_BEEF, 1'b1, 32'h2000, 4'b0011, 32'hBEEF_BEEF);
    store(2'b10, 32'h2004, 32'hDEAD_BEEF, 1'b1, 32'h2004, 4'b1111, 32'hDEAD_BEEF);
    drain();

    // misaligned / illegal: error pulse, nothing queued
    dm_ack = 1'b0;
    store(2'b01, 32'h3001, 32'h1111_1111, 1'b0, 32'h0, 4'b0, 32'h0);
    chk("err_sh", {31'd0, st_err}, 32'd1);
    chk("err_sh_busy", {31'd0, busy}, 32'd0);
    step();
    chk("err_pulse_end", {31'd0, st_err}, 32'd0);
    store(2'b10, 32'h3002, 32'h2222_2222, 1'b0, 32'h0, 4'b0, 32'h0);
    chk("err_sw", {31'd0, st_err}, 32'd1);
    step();
    store(2'b11, 32'h3000, 32'h3333_3333, 1'b0, 32'h0, 4'b0, 32'h0);
    chk("err_op11", {31'd0, st_err}, 32'd1);
    chk("err_req", {31'd0, dm_req}, 32'd0);
    step();
    chk("err_op11_end", {31'd0, st_err}, 32'd0);
    chk("err_busy", {31'd0, busy}, 32'd0);

    // full / backpressure
    store(2'b10, 32'h6000, 32'hA000_0000, 1'b1, 32'h6000, 4'b1111, 32'hA000_0000);
    store(2'b10, 32'h6004, 32'hA000_0001, 1'b1, 32'h6004, 4'b1111, 32'hA000_0001);
    store(2'b10, 32'h6008, 32'hA000_0002, 1'b1, 32'h6008, 4'b1111, 32'hA000_0002);
    chk("three_ready", {31'd0, st_ready}, 32'd1);
    store(2'b10, 32'h600C, 32'hA000_0003, 1'b1, 32'h600C, 4'b1111, 32'hA000_0003);
    chk("full_ready", {31'd0, st_ready}, 32'd0);
    st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h6010; st_data = 32'hA000_0004;
    exp_q.push_back({32'h6010, 4'b1111, 32'hA000_0004});
    step(); step();
    chk("held_ready", {31'd0, st_ready}, 32'd0);
    chk("held_addr", dm_addr, 32'h6000);
    chk("held_data", dm_wdata, 32'hA000_0000);
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    chk("after_pop_ready", {31'd0, st_ready}, 32'd1);
    chk("after_pop_head", dm_addr, 32'h6004);
    step();
    st_valid = 1'b0;
    chk("refull_ready", {31'd0, st_ready}, 32'd0);
    dm_ack = 1'b1;
    drain();
    dm_ack = 1'b0;

    // load conflict
    ld_addr = 32'h4008;
    st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h4008; st_data = 32'h1111_1111;
    exp_q.push_back({32'h4008, 4'b1111, 32'h1111_1111});
    #1;
    chk("conf_same_cycle", {31'd0, ld_conflict}, 32'd0);
    step();
    st_valid = 1'b0;
    chk("conf_queued", {31'd0, ld_conflict}, 32'd1);
    ld_addr = 32'h400B; #1;
    chk("conf_400b", {31'd0, ld_conflict}, 32'd1);
    ld_addr = 32'h400C; #1;
    chk("conf_400c", {31'd0, ld_conflict}, 32'd0);
    ld_addr = 32'h4008;
    dm_ack = 1'b1; #1;
    chk("conf_head_acked", {31'd0, ld_conflict}, 32'd1);
    step();
    dm_ack = 1'b0;
    chk("conf_after_ack", {31'd0, ld_conflict}, 32'd0);

    // reset mid-drain
    ld_addr = 32'h7004;
    store(2'b10, 32'h7000, 32'h0000_0001, 1'b0, 32'h0, 4'b0, 32'h0);
    store(2'b10, 32'h7004, 32'h0000_0002, 1'b0, 32'h0, 4'b0, 32'h0);
    store(2'b10, 32'h7008, 32'h0000_0003, 1'b0, 32'h0, 4'b0, 32'h0);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_conf", {31'd0, ld_conflict}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_req", {31'd0, dm_req}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, st_ready}, 32'd1);
    chk("mid_rst_addr", dm_addr, 32'h0);
    chk("mid_rst_conf", {31'd0, ld_conflict}, 32'd0);
    dm_ack = 1'b1;
    store(2'b00, 32'h5001, 32'h0000_0077, 1'b1, 32'h5000, 4'b0010, 32'h7777_7777);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_align_buffer.md
Name: store_align_buffer

Overview:
- Store-side counterpart of the load extension path in the pipelined CPU.
- Takes sb/sh/sw requests from the MEM stage and generates the byte enables and lane-replicated write data.
- Checks natural alignment and queues accepted stores in a small FIFO.
- Drains the FIFO to data memory over a req/ack handshake. Flags loads that hit a word with a pending store so the hazard unit can stall.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- st_valid  input  1  MEM stage presents a store this cycle.
- st_op  input  2  00 sb, 01 sh, 10 sw, 11 illegal.
- st_addr  input  32  byte address of store.
- st_data  input  32  rs2 value; low byte/half used for sb/sh.
- st_ready  output  1  buffer can accept (not full).
- st_err  output  1  one-cycle pulse: previous accepted-cycle request was misaligned or illegal.
- ld_addr  input  32  byte address of the load in MEM stage.
- ld_conflict  output  1  a buffered store targets the same word as ld_addr.
- busy  output  1  FIFO non-empty.
- dm_req  output  1  write request to data memory.
- dm_addr  output  32  word address; bits [1:0] always 0.
- dm_wdata  output  32  lane-aligned write data.
- dm_be  output  4  byte enables; bit i covers dm_wdata[8i+7:8i].
- dm_ack  input  1  memory accepted the current request.

Behaviour:
- Handshake: a store is taken when st_valid && st_ready. st_ready = !full; there is no bypass, so a full FIFO refuses the store even if a pop happens in the same cycle.
- Alignment and lane mapping, with a = st_addr[1:0]:
  - sb: any a; be = 4'b0001 << a; wdata = {4{st_data[7:0]}}.
  - sh: a[0] must be 0; be = a[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}.
  - sw: a must be 00; be = 4'b1111; wdata = st_data.
  - st_op 11: always an error.
- Error handling: a misaligned or illegal store that is taken (st_valid && st_ready) is not enqueued. st_err is registered high for exactly the next cycle. No memory side effect.
- Entry format: {addr[31:2], be, wdata}, computed combinationally at enqueue and stored.
- Drain:
  - dm_req = !empty. dm_addr, dm_wdata and dm_be come from the head entry and stay stable while dm_req=1 && dm_ack=0.
  - A pop occurs on dm_req && dm_ack.
  - When empty, dm_addr, dm_wdata and dm_be are driven to 0.
  - dm_ack while dm_req=0 is ignored.
- Latency: a store accepted at edge N appears on dm_* after edge N if the FIFO was empty. Stores drain strictly in FIFO order.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Wrap-around: pointers are modulo DEPTH. full = (count == DEPTH), empty = (count == 0), where count is a PTR_W+1 bit counter.
- ld_conflict: combinational OR over all valid entries of (entry.addr[31:2] == ld_addr[31:2]).
  - Excludes a store being accepted in the same cycle.
  - Includes the head even if it is being acked that cycle.
- busy = !empty. The hazard unit uses it for fence and drain.
- Reset: pointers=0, count=0, st_err=0, dm_req=0, dm_*=0, st_ready=1, busy=0, ld_conflict=0.
  - Reset mid-drain discards all queued stores. An in-flight request is dropped and does not persist after reset.

Test Plan:
- Byte lanes: sb to 0x1000..0x1003 with st_data=0x000000A5 → dm_be 0001, 0010, 0100, 1000 in order; dm_addr 0x1000; dm_wdata 0xA5A5A5A5 each time.
- Halfword/word: sh 0x2002 data 0x1234BEEF → be 1100, wdata 0xBEEFBEEF; sw 0x2004 data 0xDEADBEEF → be 1111, addr 0x2004.
- Misalignment: sh 0x3001, sw 0x3002, op 11 → st_err high one cycle each; dm_req never asserts; busy stays 0.
- Full/backpressure: dm_ack=0, push 5 sw → st_ready drops after 4th; 5th held; after one dm_ack, 5th accepted; drain order matches push order.
- Conflict: queue sw 0x4008; ld_addr 0x400B → ld_conflict=1; ld_addr 0x400C → 0; after ack of that entry → 0.
- Reset mid-drain: 3 entries queued, dm_ack=0, rst for 1 cycle → dm_req=0, busy=0, st_ready=1; subsequent sb to 0x5001 drains normally with be 0010.
